// File: rtl/exec_pkg.sv
// Shared definitions for the vector execute pipe: ALU op codes, divider FSM states,
// the record of fields carried alongside each result, and a lane-slice helper.
package exec_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;
    localparam logic [2:0] ALU_DIV = 3'd3;
    localparam logic [2:0] ALU_DOT = 3'd4;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [3:0]  rt;
        logic [15:0] pc;
        logic        vec;
    } meta_t;

    // Low bit index of a lane inside a packed LANES*WIDTH operand.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/exec_vector_pipe_if.sv
// Decode-side and writeback-side handshake bundle of the vector execute pipe.
// The pipe connects through the slave modport; the driver of decode/writeback uses master.
interface exec_vector_pipe_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 16
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             in_op;
    logic                   in_vec;
    logic [3:0]             in_rt;
    logic [15:0]            in_pc;
    logic [LANES*WIDTH-1:0] in_ra_val;
    logic [LANES*WIDTH-1:0] in_rx_val;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0]             out_rt;
    logic [15:0]            out_pc;
    logic                   out_vec;
    logic [LANES*WIDTH-1:0] out_result;
    logic                   busy;

    modport master (
        output flush, in_valid, in_op, in_vec, in_rt, in_pc, in_ra_val, in_rx_val, out_ready,
        input  in_ready, out_valid, out_rt, out_pc, out_vec, out_result, busy
    );

    modport slave (
        input  flush, in_valid, in_op, in_vec, in_rt, in_pc, in_ra_val, in_rx_val, out_ready,
        output in_ready, out_valid, out_rt, out_pc, out_vec, out_result, busy
    );
endinterface

// File: rtl/exec_lane_divider.sv
// One-lane unsigned restoring divider: one quotient bit per step, WIDTH steps total.
// A zero divisor naturally yields an all-ones quotient.
module exec_lane_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] quotient_step
);
    logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d, rem_step;
    logic [WIDTH:0]   rem_shift;
    logic             ge;

    // quotient_step is the register content after one more step, so the owner can
    // capture the final quotient on the same edge as the last step.
    always_comb begin
        rem_shift     = {rem_q, quot_q[WIDTH-1]};
        ge            = rem_shift >= {1'b0, dvs_q};
        rem_step      = ge ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
        quotient_step = {quot_q[WIDTH-2:0], ge};
    end

    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        dvs_d  = dvs_q;
        if (abort) begin
            rem_d  = '0;
            quot_d = '0;
            dvs_d  = '0;
        end else if (start) begin
            rem_d  = '0;
            quot_d = dividend;
            dvs_d  = divisor;
        end else if (step) begin
            rem_d  = rem_step;
            quot_d = quotient_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvs_q  <= dvs_d;
        end
    end

    assign quotient = quot_q;

endmodule

// File: rtl/exec_vector_pipe.sv
// LANES-wide SIMD execute pipe with DEPTH result stages, valid/ready, flush and an
// iterative divider. Define EXEC_VDOT_EN to build the ALU_DOT reduction.
module exec_vector_pipe
    import exec_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    exec_vector_pipe_if.slave io
);
    localparam int LW = LANES * WIDTH;
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] lane_alu       [LANES];
    logic [WIDTH-1:0] lane_prod      [LANES];
    logic [WIDTH-1:0] lane_quot      [LANES];
    logic [WIDTH-1:0] lane_quot_step [LANES];
    logic [LW-1:0]    alu_res, div_res;

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    meta_t            div_meta_q, div_meta_d, in_meta;

    logic [DEPTH-1:0]           vld_q, vld_d, adv;
    meta_t [DEPTH-1:0]          meta_q, meta_d;
    logic [DEPTH-1:0][LW-1:0]   res_q, res_d;

    logic s0_free, accept, is_div, div_start, div_step, div_wr, div_use_step;

    assign in_meta   = {io.in_rt, io.in_pc, io.in_vec};
    assign is_div    = (io.in_op == ALU_DIV);
    assign s0_free   = !vld_q[0] || adv[0];
    assign io.in_ready = s0_free && (state_q == DIV_IDLE) && !io.flush && !rst;
    assign accept    = io.in_valid && io.in_ready;
    assign div_start = accept && is_div;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam bit SCALAR = (gi == 0);
        logic [WIDTH-1:0] a, x, lane_r;

        assign a = io.in_ra_val[lane_lo(gi, WIDTH) +: WIDTH];
        assign x = io.in_rx_val[lane_lo(gi, WIDTH) +: WIDTH];
        assign lane_prod[gi] = a * x;

        always_comb begin
            lane_r = '0;
            if (io.in_vec || SCALAR) begin
                case (io.in_op)
                    ALU_ADD: lane_r = a + x;
                    ALU_SUB: lane_r = x - a;
                    ALU_MUL: lane_r = lane_prod[gi];
                    default: lane_r = '0;
                endcase
            end
        end
        assign lane_alu[gi] = lane_r;

        exec_lane_divider #(.WIDTH(WIDTH)) u_div (
            .clk          (clk),
            .rst          (rst),
            .start        (div_start),
            .step         (div_step),
            .abort        (io.flush),
            .dividend     (x),
            .divisor      (a),
            .quotient     (lane_quot[gi]),
            .quotient_step(lane_quot_step[gi])
        );
    end

`ifdef EXEC_VDOT_EN
    logic [WIDTH-1:0] dot_sum;
    always_comb begin
        dot_sum = '0;
        for (int i = 0; i < LANES; i++) dot_sum = dot_sum + lane_prod[i];
    end
`endif

    always_comb begin
        alu_res = '0;
        div_res = '0;
        for (int i = 0; i < LANES; i++) begin
            alu_res[lane_lo(i, WIDTH) +: WIDTH] = lane_alu[i];
            if (div_meta_q.vec || i == 0)
                div_res[lane_lo(i, WIDTH) +: WIDTH] = div_use_step ? lane_quot_step[i] : lane_quot[i];
        end
`ifdef EXEC_VDOT_EN
        if (io.in_op == ALU_DOT) begin
            alu_res = '0;
            alu_res[WIDTH-1:0] = dot_sum;
        end
`endif
    end

    // Divider sequencing; the last RUN edge writes straight into stage 0 when it can.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_step     = 1'b0;
        div_wr       = 1'b0;
        div_use_step = 1'b0;
        div_meta_d   = div_start ? in_meta : div_meta_q;
        case (state_q)
            DIV_IDLE: begin
                if (div_start) begin
                    state_d = DIV_RUN;
                    cnt_d   = '0;
                end
            end
            DIV_RUN: begin
                div_step = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    if (s0_free) begin
                        div_wr       = 1'b1;
                        div_use_step = 1'b1;
                        state_d      = DIV_IDLE;
                    end else begin
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                if (s0_free) begin
                    div_wr  = 1'b1;
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
        if (io.flush) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        adv[DEPTH-1] = vld_q[DEPTH-1] && io.out_ready;
        for (int k = DEPTH - 2; k >= 0; k--)
            adv[k] = vld_q[k] && (!vld_q[k+1] || adv[k+1]);
    end

    always_comb begin
        vld_d  = vld_q;
        meta_d = meta_q;
        res_d  = res_q;
        if (adv[0]) vld_d[0] = 1'b0;
        if (div_wr) begin
            vld_d[0]  = 1'b1;
            meta_d[0] = div_meta_q;
            res_d[0]  = div_res;
        end else if (accept && !is_div) begin
            vld_d[0]  = 1'b1;
            meta_d[0] = in_meta;
            res_d[0]  = alu_res;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (adv[k]) vld_d[k] = 1'b0;
            if (adv[k-1]) begin
                vld_d[k]  = 1'b1;
                meta_d[k] = meta_q[k-1];
                res_d[k]  = res_q[k-1];
            end
        end
        if (io.flush) begin
            vld_d  = '0;
            meta_d = '0;
            res_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            div_meta_q <= '0;
            vld_q      <= '0;
            meta_q     <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_meta_q <= div_meta_d;
            vld_q      <= vld_d;
            meta_q     <= meta_d;
            res_q      <= res_d;
        end
    end

    assign io.out_valid  = vld_q[DEPTH-1];
    assign io.out_result = res_q[DEPTH-1];
    assign io.out_rt     = meta_q[DEPTH-1].rt;
    assign io.out_pc     = meta_q[DEPTH-1].pc;
    assign io.out_vec    = meta_q[DEPTH-1].vec;
    assign io.busy       = (state_q != DIV_IDLE) || (|vld_q);

endmodule

// File: tb/tb_exec_vector_pipe.sv
// Scoreboard bench for exec_vector_pipe (LANES=4, WIDTH=16, DEPTH=2): expected results
// are queued at issue and compared in order as writeback consumes them.
module tb_exec_vector_pipe;
    import exec_pkg::*;

    localparam int LANES = 4;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int LW    = LANES * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_out = 0;
    logic [15:0] pc_ctr = 16'h0100;

    typedef struct {
        logic [LW-1:0] res;
        logic [3:0]    rt;
        logic [15:0]   pc;
        logic          vec;
        int            exp_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    exec_vector_pipe_if #(.LANES(LANES), .WIDTH(WIDTH)) io();

    exec_vector_pipe #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] pack(input logic [15:0] l0, input logic [15:0] l1,
                                           input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [LW-1:0] model(input logic [2:0] op, input logic vec,
                                            input logic [LW-1:0] a, input logic [LW-1:0] x);
        logic [LW-1:0]    r;
        logic [WIDTH-1:0] ai, xi, ri, dot;
        r   = '0;
        dot = '0;
        for (int i = 0; i < LANES; i++) begin
            ai  = a[i*WIDTH +: WIDTH];
            xi  = x[i*WIDTH +: WIDTH];
            dot = dot + ai * xi;
            case (op)
                ALU_ADD: ri = ai + xi;
                ALU_SUB: ri = xi - ai;
                ALU_MUL: ri = ai * xi;
                ALU_DIV: ri = (ai == 16'd0) ? 16'hFFFF : xi / ai;
                default: ri = '0;
            endcase
            if (!vec && i != 0) ri = '0;
            r[i*WIDTH +: WIDTH] = ri;
        end
        if (op == ALU_DOT) begin
            r = '0;
`ifdef EXEC_VDOT_EN
            r[WIDTH-1:0] = dot;
`endif
        end
        return r;
    endfunction

    // Writeback side: every consumed result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && io.out_valid === 1'b1 && io.out_ready === 1'b1) begin
            $display("out pc=%h rt=%h vec=%0d result=%h cyc=%0d", io.out_pc, io.out_rt, io.out_vec, io.out_result, cyc);
            n_out++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output pc=%h result=%h required=none", io.out_pc, io.out_result);
            end else begin
                mon_e = sb.pop_front();
                if (io.out_result !== mon_e.res) begin
                    failures++;
                    $display("FAIL result pc=%h got=%h required=%h", mon_e.pc, io.out_result, mon_e.res);
                end
                checks++;
                if ({io.out_rt, io.out_pc, io.out_vec} !== {mon_e.rt, mon_e.pc, mon_e.vec}) begin
                    failures++;
                    $display("FAIL carried_fields got rt=%h pc=%h vec=%0d required rt=%h pc=%h vec=%0d",
                             io.out_rt, io.out_pc, io.out_vec, mon_e.rt, mon_e.pc, mon_e.vec);
                end
                if (mon_e.exp_cyc >= 0) begin
                    checks++;
                    if (cyc !== mon_e.exp_cyc) begin
                        failures++;
                        $display("FAIL latency pc=%h got_cycle=%0d required_cycle=%0d", mon_e.pc, cyc, mon_e.exp_cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic vec, input logic [LW-1:0] a,
                         input logic [LW-1:0] x, input bit push, input int lat, output int t_acc);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        t_acc = -1;
        io.in_valid  = 1'b1;
        io.in_op     = op;
        io.in_vec    = vec;
        io.in_ra_val = a;
        io.in_rx_val = x;
        io.in_pc     = pc_ctr;
        io.in_rt     = pc_ctr[3:0];
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (io.in_ready === 1'b1) begin
                ok = 1'b1;
                t_acc = cyc;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout pc=%h in_ready=%b required=1 within 100 cycles", pc_ctr, io.in_ready);
        end else if (push) begin
            e.res     = model(op, vec, a, x);
            e.rt      = pc_ctr[3:0];
            e.pc      = pc_ctr;
            e.vec     = vec;
            e.exp_cyc = (lat < 0) ? -1 : t_acc + lat;
            sb.push_back(e);
        end
        $display("issue op=%0d vec=%0d pc=%h cyc=%0d", op, vec, pc_ctr, t_acc);
        pc_ctr = pc_ctr + 16'd1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        io.flush     = 1'b0;
        io.in_valid  = 1'b1;
        io.in_op     = ALU_ADD;
        io.in_vec    = 1'b1;
        io.in_rt     = 4'h0;
        io.in_pc     = 16'h0;
        io.in_ra_val = '0;
        io.in_rx_val = '0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b required=0", io.in_ready); end
        checks++;
        if (io.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b required=0", io.out_valid); end
        checks++;
        if (io.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", io.busy); end
        checks++;
        if (io.out_result !== '0) begin failures++; $display("FAIL reset_out_result got=%h required=0", io.out_result); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        io.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b required=1", io.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu();
        int t0, t1, t2, t3, t4, t5;
        issue(ALU_ADD, 1'b1, pack(16'd1, 16'd2, 16'd3, 16'd4), pack(16'd10, 16'd20, 16'd30, 16'd40), 1'b1, DEPTH, t0);
        issue(ALU_SUB, 1'b1, pack(16'd5, 16'd5, 16'd5, 16'd5), pack(16'd3, 16'd3, 16'd3, 16'd3), 1'b1, DEPTH, t1);
        issue(ALU_MUL, 1'b1, pack(16'h0100, 16'h0100, 16'h0100, 16'h0100), pack(16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b1, DEPTH, t2);
        issue(ALU_ADD, 1'b0, pack(16'd1, 16'd2, 16'd3, 16'd4), pack(16'd7, 16'd7, 16'd7, 16'd7), 1'b1, DEPTH, t3);
        issue(ALU_MUL, 1'b1, pack(16'd300, 16'hFFFF, 16'd12, 16'd0), pack(16'd500, 16'd3, 16'd11, 16'd9), 1'b1, DEPTH, t4);
        issue(3'd6, 1'b1, pack(16'd9, 16'd9, 16'd9, 16'd9), pack(16'd1, 16'd1, 16'd1, 16'd1), 1'b1, DEPTH, t5);
        checks++;
        if (t5 - t0 !== 5) begin
            failures++;
            $display("FAIL alu_throughput got_span=%0d required_span=5", t5 - t0);
        end
        wait_drain("alu");
    endtask

    task automatic test_div();
        int t0, t1, t2, lows;
        issue(ALU_DIV, 1'b1, pack(16'd7, 16'd3, 16'd5, 16'd0), pack(16'd100, 16'd9, 16'd0, 16'd65535), 1'b1, WIDTH + DEPTH, t0);
        lows = 0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (io.in_ready === 1'b0) lows++;
        end
        checks++;
        if (lows !== WIDTH) begin failures++; $display("FAIL div_in_ready_low got=%0d required=%0d", lows, WIDTH); end
        checks++;
        if (io.busy !== 1'b1) begin failures++; $display("FAIL div_busy got=%b required=1", io.busy); end
        issue(ALU_ADD, 1'b1, pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd2, 16'd2, 16'd2, 16'd2), 1'b1, DEPTH, t1);
        checks++;
        if (t1 !== t0 + WIDTH + 1) begin failures++; $display("FAIL div_next_accept got=%0d required=%0d", t1, t0 + WIDTH + 1); end
        wait_drain("div");
        issue(ALU_DIV, 1'b0, pack(16'd5, 16'd1, 16'd1, 16'd1), pack(16'd50, 16'd8, 16'd8, 16'd8), 1'b1, WIDTH + DEPTH, t2);
        wait_drain("div_scalar");
    endtask

    task automatic test_backpressure();
        int t, n0, stalled;
        n0 = n_out;
        io.out_ready = 1'b0;
        issue(ALU_ADD, 1'b1, pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd100, 16'd200, 16'd300, 16'd400), 1'b1, -1, t);
        issue(ALU_ADD, 1'b1, pack(16'd2, 16'd2, 16'd2, 16'd2), pack(16'd100, 16'd200, 16'd300, 16'd400), 1'b1, -1, t);
        io.in_valid = 1'b1;
        io.in_op    = ALU_ADD;
        stalled = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (io.in_ready === 1'b0 && io.out_valid === 1'b1) stalled++;
        end
        checks++;
        if (stalled !== 3) begin failures++; $display("FAIL bp_stall got=%0d required=3", stalled); end
        @(posedge clk);
        #1;
        io.out_ready = 1'b1;
        issue(ALU_ADD, 1'b1, pack(16'd3, 16'd3, 16'd3, 16'd3), pack(16'd100, 16'd200, 16'd300, 16'd400), 1'b1, -1, t);
        wait_drain("bp");
        checks++;
        if (n_out - n0 !== 3) begin failures++; $display("FAIL bp_out_count got=%0d required=3", n_out - n0); end
    endtask

    task automatic test_flush();
        int t, seen;
        issue(ALU_DIV, 1'b1, pack(16'd3, 16'd3, 16'd3, 16'd3), pack(16'd99, 16'd99, 16'd99, 16'd99), 1'b0, -1, t);
        repeat (7) @(posedge clk);
        #1;
        io.flush    = 1'b1;
        io.in_valid = 1'b1;
        io.in_op    = ALU_ADD;
        @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b0) begin failures++; $display("FAIL flush_cycle_in_ready got=%b required=0", io.in_ready); end
        @(posedge clk);
        #1;
        io.flush    = 1'b0;
        io.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (io.busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b required=0", io.busy); end
        checks++;
        if (io.in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b required=1", io.in_ready); end
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (io.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL flush_no_output got=%0d required=0", seen); end
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        issue(ALU_ADD, 1'b1, pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd1, 16'd1, 16'd1, 16'd1), 1'b0, -1, t);
        issue(ALU_ADD, 1'b1, pack(16'd2, 16'd2, 16'd2, 16'd2), pack(16'd2, 16'd2, 16'd2, 16'd2), 1'b0, -1, t);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (io.out_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_out_valid got=%b required=1", io.out_valid); end
        checks++;
        if (io.in_ready !== 1'b0) begin failures++; $display("FAIL rst_cycle_in_ready got=%b required=0", io.in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (io.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b required=0", io.out_valid); end
        checks++;
        if (io.out_result !== '0) begin failures++; $display("FAIL rst_out_result got=%h required=0", io.out_result); end
        @(posedge clk);
        #1;
        io.out_ready = 1'b1;
    endtask

    task automatic test_dot();
        int t;
        issue(ALU_DOT, 1'b0, pack(16'd1, 16'd2, 16'd3, 16'd4), pack(16'd5, 16'd6, 16'd7, 16'd8), 1'b1, DEPTH, t);
        issue(ALU_DOT, 1'b1, pack(16'h1000, 16'd2, 16'h0100, 16'd4), pack(16'h0010, 16'd6, 16'h0100, 16'd8), 1'b1, DEPTH, t);
        wait_drain("dot");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_div();
        test_backpressure();
        test_flush();
        test_dot();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL final_scoreboard pending=%0d required=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
